// File: rtl/fetch_pc.sv
// fetch_pc: IFU fetch program counter. Sequential 16/32-bit increment, prioritised
// trap/jump redirects with a stall-safe pending slot, and a circular return-address stack.
module fetch_pc #(
   parameter int unsigned       XLEN      = 32,
   parameter logic [XLEN-1:0]   RESET_VEC = XLEN'(32'h8000_0000),
   parameter int unsigned       RAS_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               stall,
   input  logic                               compressed,
   input  logic                               is_call,
   input  logic                               is_ret,
   input  logic                               je,
   input  logic [XLEN-1:0]                    ja,
   input  logic                               trap_en,
   input  logic [XLEN-1:0]                    trap_vec,
   output logic [XLEN-1:0]                    curr_pc,
   output logic [XLEN-1:0]                    inc_pc,
   output logic [XLEN-1:0]                    next_pc,
   output logic                               pred_ret,
   output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count
);

   localparam int unsigned     CW       = $clog2(RAS_DEPTH + 1);
   localparam int unsigned     PW       = $clog2(RAS_DEPTH);
   localparam logic [CW-1:0]   RAS_FULL = CW'(RAS_DEPTH);

   logic                pend_valid;
   logic [XLEN-1:0]     pend_addr;

   logic [XLEN-1:0]     ras_mem [RAS_DEPTH];
   logic [PW-1:0]       ras_ptr;
   logic [PW-1:0]       ras_waddr;
   logic [XLEN-1:0]     ras_top;

   logic                new_redir;
   logic                redir;
   logic [XLEN-1:0]     redir_addr;
   logic                ras_nonempty;
   logic                ras_upd;
   logic                push_new;
   logic                replace_top;
   logic                pop;
   logic                ras_we;

   assign inc_pc = curr_pc + (compressed ? XLEN'(2) : XLEN'(4));

   // A fresh redirect always outranks the one parked while fetch was stalled.
   assign new_redir  = trap_en | je;
   assign redir      = new_redir | pend_valid;
   assign redir_addr = trap_en ? trap_vec : (je ? ja : pend_addr);

   assign ras_nonempty = (ras_count != '0);
   assign ras_top      = ras_mem[ras_ptr];

   // Hints are only trusted on a cycle that actually advances down the predicted path.
   assign ras_upd     = !stall && !redir;
   assign pred_ret    = ras_upd && is_ret && ras_nonempty;
   assign push_new    = ras_upd && is_call && (!is_ret || !ras_nonempty);
   assign replace_top = ras_upd && is_call && is_ret && ras_nonempty;
   assign pop         = ras_upd && is_ret && !is_call && ras_nonempty;
   assign ras_we      = push_new || replace_top;
   assign ras_waddr   = push_new ? ras_ptr + 1'b1 : ras_ptr;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      next_pc = inc_pc;
      if (stall) begin
         next_pc = curr_pc;
      end else if (redir) begin
         next_pc = redir_addr;
      end else if (pred_ret) begin
         next_pc = ras_top;
      end
   end

   // NOTE: registered state is written with non-blocking assignments so all flops
   // sample the same pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         curr_pc    <= RESET_VEC;
         pend_valid <= 1'b0;
         pend_addr  <= '0;
      end else begin
         curr_pc <= next_pc;
         if (!stall) begin
            pend_valid <= 1'b0;
         end else if (new_redir) begin
            pend_valid <= 1'b1;
            pend_addr  <= redir_addr;
         end
      end
   end

   // Trap flushes the stack even while stalled; the pointer restarts so reset and flush look alike.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ras_ptr   <= '0;
         ras_count <= '0;
      end else if (trap_en) begin
         ras_ptr   <= '0;
         ras_count <= '0;
      end else if (push_new) begin
         ras_ptr <= ras_ptr + 1'b1;
         if (ras_count != RAS_FULL) begin
            ras_count <= ras_count + 1'b1;
         end
      end else if (pop) begin
         ras_ptr   <= ras_ptr - 1'b1;
         ras_count <= ras_count - 1'b1;
      end
   end

   // NOTE: the RAS array has no reset; an entry is only read once ras_count marks it
   // valid, so clearing it would cost a reset net on every bit for nothing.
   always_ff @(posedge clk) begin
      if (ras_we) begin
         ras_mem[ras_waddr] <= inc_pc;
      end
   end

endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed stimulus for fetch_pc, checked every cycle against a queue-based
// model of the fetch/redirect/RAS rules plus hand-computed literal expectations.
module tb_fetch_pc;

   localparam int DEPTH = 4;
   localparam logic [31:0] RV = 32'h8000_0000;

   logic        clk;
   logic        reset;
   logic        stall, compressed, is_call, is_ret, je, trap_en;
   logic [31:0] ja, trap_vec;
   logic [31:0] curr_pc, inc_pc, next_pc;
   logic        pred_ret;
   logic [2:0]  ras_count;

   int n_cmp  = 0;
   int n_fail = 0;

   fetch_pc #(.XLEN(32), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .compressed (compressed),
      .is_call    (is_call),
      .is_ret     (is_ret),
      .je         (je),
      .ja         (ja),
      .trap_en    (trap_en),
      .trap_vec   (trap_vec),
      .curr_pc    (curr_pc),
      .inc_pc     (inc_pc),
      .next_pc    (next_pc),
      .pred_ret   (pred_ret),
      .ras_count  (ras_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: fetch PC, pending redirect slot, and the RAS as a bounded queue.
   logic [31:0] m_pc = RV;
   logic        m_pv = 1'b0;
   logic [31:0] m_pa = 32'h0;
   logic [31:0] m_ras [$];

   task automatic model_outs(output logic [31:0] inc, output logic [31:0] nx, output logic pr);
      logic        rd;
      logic [31:0] sel;
      inc = m_pc + (compressed ? 32'd2 : 32'd4);
      rd  = trap_en || je || m_pv;
      sel = trap_en ? trap_vec : (je ? ja : m_pa);
      pr  = !stall && !rd && is_ret && (m_ras.size() > 0);
      if (stall)   nx = m_pc;
      else if (rd) nx = sel;
      else if (pr) nx = m_ras[m_ras.size()-1];
      else         nx = inc;
   endtask

   always @(posedge clk or posedge reset) begin
      logic [31:0] inc, nx;
      logic        pr, rd;
      if (reset) begin
         m_pc = RV;
         m_pv = 1'b0;
         m_pa = 32'h0;
         m_ras.delete();
      end else begin
         model_outs(inc, nx, pr);
         rd = trap_en || je || m_pv;
         if (trap_en) begin
            m_ras.delete();
         end else if (!stall && !rd) begin
            if (is_call && is_ret) begin
               if (m_ras.size() > 0) m_ras[m_ras.size()-1] = inc;
               else                  m_ras.push_back(inc);
            end else if (is_call) begin
               m_ras.push_back(inc);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (is_ret && m_ras.size() > 0) begin
               void'(m_ras.pop_back());
            end
         end
         if (!stall) begin
            m_pc = nx;
            m_pv = 1'b0;
         end else if (trap_en || je) begin
            m_pv = 1'b1;
            m_pa = trap_en ? trap_vec : ja;
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] inc, nx;
      logic        pr;
      model_outs(inc, nx, pr);
      check("mdl_curr_pc", curr_pc, m_pc);
      check("mdl_inc_pc", inc_pc, inc);
      check("mdl_next_pc", next_pc, nx);
      check("mdl_pred_ret", 32'(pred_ret), 32'(pr));
      check("mdl_ras_count", 32'(ras_count), 32'(m_ras.size()));
   end

   // Advance one cycle: inputs change just after the rising edge, default to idle.
   task automatic nxt();
      @(posedge clk);
      #1;
      stall = 0; compressed = 0; is_call = 0; is_ret = 0; je = 0; trap_en = 0;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      reset = 1; stall = 0; compressed = 0; is_call = 0; is_ret = 0;
      je = 0; trap_en = 0; ja = 0; trap_vec = 0;

      smp();
      check("rst_curr", curr_pc, 32'h8000_0000);
      check("rst_inc", inc_pc, 32'h8000_0004);
      check("rst_pred", 32'(pred_ret), 32'd0);
      check("rst_cnt", 32'(ras_count), 32'd0);

      // Sequential fetch: 32, 32, 16-bit.
      @(posedge clk); #1 reset = 0;
      smp(); check("seq0_curr", curr_pc, 32'h8000_0000); check("seq0_next", next_pc, 32'h8000_0004);
      nxt(); smp(); check("seq1_curr", curr_pc, 32'h8000_0004);
      nxt(); compressed = 1; smp();
      check("seq2_curr", curr_pc, 32'h8000_0008); check("seq2_inc", inc_pc, 32'h8000_000A);

      // Jump arriving mid-stall is held and applied on release.
      nxt(); stall = 1; smp(); check("stl_curr", curr_pc, 32'h8000_000A); check("stl_next", next_pc, 32'h8000_000A);
      nxt(); stall = 1; je = 1; ja = 32'h0000_1000; smp(); check("stl_je_next", next_pc, 32'h8000_000A);
      nxt(); stall = 1; smp(); check("stl_hold", curr_pc, 32'h8000_000A);
      nxt(); smp(); check("rel_next", next_pc, 32'h0000_1000);
      nxt(); smp(); check("rel_curr", curr_pc, 32'h0000_1000);

      // Trap and jump in the same stalled cycle: trap wins.
      nxt(); stall = 1; smp();
      nxt(); stall = 1; je = 1; ja = 32'h0000_2000; trap_en = 1; trap_vec = 32'h0000_3000; smp();
      nxt(); smp(); check("trp_rel_next", next_pc, 32'h0000_3000);
      nxt(); smp(); check("trp_rel_curr", curr_pc, 32'h0000_3000);

      // Fresh jump in the release cycle outranks the pending one.
      nxt(); stall = 1; je = 1; ja = 32'h0000_4000; smp();
      nxt(); je = 1; ja = 32'h0000_5000; smp(); check("fresh_next", next_pc, 32'h0000_5000);

      // Call / return.
      nxt(); trap_en = 1; trap_vec = 32'h8000_0010; smp();
      nxt(); is_call = 1; smp(); check("call_curr", curr_pc, 32'h8000_0010); check("call_next", next_pc, 32'h8000_0014);
      nxt(); smp(); check("call_cnt", 32'(ras_count), 32'd1);
      nxt(); is_ret = 1; smp();
      check("ret_pred", 32'(pred_ret), 32'd1); check("ret_next", next_pc, 32'h8000_0014);
      nxt(); is_ret = 1; smp();
      check("ret2_cnt", 32'(ras_count), 32'd0); check("ret2_pred", 32'(pred_ret), 32'd0);
      check("ret2_next", next_pc, 32'h8000_0018);

      // Overflow: five calls into a four-entry stack.
      for (int i = 1; i <= 5; i++) begin
         nxt(); je = 1; ja = 32'(i) << 8; smp();
         nxt(); is_call = 1; smp(); check("ovf_call_pc", curr_pc, 32'(i) << 8);
      end
      nxt(); smp(); check("ovf_cnt", 32'(ras_count), 32'd4);
      for (int i = 5; i >= 2; i--) begin
         nxt(); is_ret = 1; smp();
         check("ovf_pred", 32'(pred_ret), 32'd1); check("ovf_ret_next", next_pc, (32'(i) << 8) + 32'd4);
      end
      nxt(); is_ret = 1; smp();
      check("ovf_empty_pred", 32'(pred_ret), 32'd0); check("ovf_empty_next", next_pc, 32'h0000_0208);

      // Simultaneous call+ret with one entry, then with none.
      nxt(); trap_en = 1; trap_vec = 32'h0000_0100; smp();
      nxt(); is_call = 1; smp();
      nxt(); je = 1; ja = 32'h0000_0600; smp();
      nxt(); is_call = 1; is_ret = 1; smp();
      check("cr1_pred", 32'(pred_ret), 32'd1); check("cr1_next", next_pc, 32'h0000_0104);
      nxt(); is_ret = 1; smp();
      check("cr1_cnt", 32'(ras_count), 32'd1); check("cr1_top", next_pc, 32'h0000_0604);
      nxt(); je = 1; ja = 32'h0000_0600; smp(); check("cr0_cnt0", 32'(ras_count), 32'd0);
      nxt(); is_call = 1; is_ret = 1; smp();
      check("cr0_pred", 32'(pred_ret), 32'd0); check("cr0_next", next_pc, 32'h0000_0604);
      nxt(); is_ret = 1; smp();
      check("cr0_cnt", 32'(ras_count), 32'd1); check("cr0_top", next_pc, 32'h0000_0604);

      // Trap flush, including while stalled.
      nxt(); trap_en = 1; trap_vec = 32'h0000_0700; smp();
      repeat (3) begin nxt(); is_call = 1; smp(); end
      nxt(); trap_en = 1; trap_vec = 32'h0000_0900; smp();
      check("flush_cnt3", 32'(ras_count), 32'd3); check("flush_next", next_pc, 32'h0000_0900);
      nxt(); is_call = 1; smp(); check("flush_cnt0", 32'(ras_count), 32'd0);
      nxt(); stall = 1; trap_en = 1; trap_vec = 32'h0000_0A00; smp(); check("stl_trap_cnt1", 32'(ras_count), 32'd1);
      nxt(); stall = 1; smp(); check("stl_trap_cnt0", 32'(ras_count), 32'd0); check("stl_trap_curr", curr_pc, 32'h0000_0904);
      nxt(); smp(); check("stl_trap_next", next_pc, 32'h0000_0A00);

      // Wrap-around of the sequential increment.
      nxt(); je = 1; ja = 32'hFFFF_FFFE; smp();
      nxt(); compressed = 1; smp(); check("wrap_inc", inc_pc, 32'h0000_0000); check("wrap_next", next_pc, 32'h0000_0000);

      // Reset mid-stall drops the pending jump and the RAS.
      nxt(); is_call = 1; smp();
      nxt(); stall = 1; je = 1; ja = 32'h0000_0B00; smp(); check("mid_cnt", 32'(ras_count), 32'd1);
      #2 reset = 1;
      #1 check("mid_rst_curr", curr_pc, 32'h8000_0000); check("mid_rst_cnt", 32'(ras_count), 32'd0);
      nxt(); reset = 0; smp(); check("mid_rel_next", next_pc, 32'h8000_0004);
      nxt(); smp(); check("mid_rel_curr", curr_pc, 32'h8000_0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Parametrised fetch program counter for the IFU: holds the current fetch address, computes the sequential successor for 16/32-bit instructions, and applies trap/jump redirects with a fixed priority. A redirect that arrives while fetch is stalled is held in a pending register, so it is never lost. A small circular return-address stack (RAS) predicts return targets from predecode call/return hints. It sits between IFU predecode and the instruction memory request, and receives redirects from execute and the trap unit.

## Interface
- XLEN, 32, address width
- RESET_VEC, 32'h8000_0000, value of curr_pc after reset; low XLEN bits are used
- RAS_DEPTH, 4, RAS entries, ≥2, power of two
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold curr_pc this cycle
- compressed  in  1  instruction at curr_pc is 16-bit
- is_call  in  1  predecode: instruction at curr_pc is a call (writes ra)
- is_ret  in  1  predecode: instruction at curr_pc is a return
- je  in  1  jump/mispredict redirect from execute
- ja  in  XLEN  redirect target for je
- trap_en  in  1  trap/exception redirect
- trap_vec  in  XLEN  trap target
- curr_pc  out  XLEN  registered fetch address
- inc_pc  out  XLEN  sequential successor of curr_pc
- next_pc  out  XLEN  value curr_pc takes at the next edge
- pred_ret  out  1  next_pc is a RAS prediction this cycle
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries

## Operation
- inc_pc = curr_pc + (compressed ? 2 : 4), modulo 2^XLEN. Wrap-around from all-ones is silent.
- Redirect select, highest first: trap_en→trap_vec, je→ja, pend_valid→pend_addr. redir = trap_en | je | pend_valid.
- next_pc priority:
  - stall: curr_pc
  - else redir: selected redirect address
  - else is_ret & ras_count>0: RAS top
  - else inc_pc
- pred_ret = !stall & !redir & is_ret & ras_count>0.
- Pending register (pend_valid, pend_addr):
  - stall & (trap_en|je): set pend_valid=1 and pend_addr=selected new address. A newer redirect overwrites an older one.
  - stall with no new redirect: hold.
  - !stall: clear pend_valid, because the redirect was consumed this cycle.
- RAS is a circular buffer with a top pointer. It updates only when !stall & !redir; call/ret hints on a wrong-path cycle are ignored.
  - push (is_call only): write inc_pc above top, advance pointer. ras_count saturates at RAS_DEPTH; on overflow the oldest entry is overwritten.
  - pop (is_ret only, count>0): retreat pointer, count−1. Pop when empty: no prediction, no state change.
  - is_call & is_ret together: prediction uses old top. Top is then replaced with inc_pc and count is unchanged. If count was 0: no prediction, push only, count→1.
- trap_en clears the RAS to ras_count=0, even when stalled. je does not modify the RAS (no recovery).

## Timing
- Reset (async, immediate): curr_pc=RESET_VEC, pend_valid=0, pend_addr=0, ras_count=0, RAS pointer=0, RAS entries don't-care.
- Combinational outputs follow register values during reset: inc_pc=RESET_VEC+2/4, pred_ret=0.
- next_pc, inc_pc and pred_ret are combinational from current inputs and state. curr_pc updates one cycle later.
- Redirect without stall: target appears on curr_pc at the next edge (1-cycle latency).
- Redirect during stall: applied on the first cycle stall=0, reaching curr_pc one edge later. A fresh trap_en/je in that release cycle takes priority over the pending address.
- Reset asserted mid-stall discards any pending redirect and RAS contents.

## Test plan
- Reset and sequential fetch: release reset with stall=0, compressed=0,0,1 → curr_pc 8000_0000, 8000_0004, 8000_0008, 8000_000A. pred_ret=0, ras_count=0.
- Stalled redirect: stall=1 for 3 cycles, je=1, ja=0000_1000 in the 2nd cycle. curr_pc holds; the cycle stall drops gives next_pc=0000_1000; curr_pc=0000_1000 next edge. Repeat with trap_en+je in the same stalled cycle → trap_vec wins.
- Call/return: is_call at curr_pc=8000_0010 (32-bit) → ras_count=1. Later is_ret → pred_ret=1, next_pc=8000_0014, ras_count=0. Second is_ret → pred_ret=0, next_pc=inc_pc.
- RAS overflow: RAS_DEPTH=4, 5 calls from PCs 100,200,300,400,500 → count=4. Returns predict 504,404,304,204, then no prediction.
- Simultaneous call+ret with count=1 (top=104) at curr_pc=600 → next_pc=104, top becomes 604, count stays 1. Same with count=0 → next_pc=604, count=1.
- Trap flush and wrap: trap_en with count=3 → count=0, next_pc=trap_vec. curr_pc=FFFF_FFFE with compressed=1 → inc_pc=0000_0000.
